// File: rtl/schematic_test_checker.sv
// Stimulus/response sequencer for the 1-in/16-out schematic test block: sweeps stim 0/1,
// samples the DUT result after a settle delay and accumulates masked mismatch statistics.
module schematic_test_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 4,
  parameter int unsigned ERR_W         = 8,
  parameter logic [15:0] EXP_LO        = 16'hFA52,
  parameter logic [15:0] EXP_HI        = 16'hFA15,
  parameter logic [15:0] CHECK_MASK    = 16'hFF7F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim,
  input  logic [15:0]      dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail_vec,
  output logic             first_fail_stim
);

  localparam int WAIT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PASS_W = $clog2(PASSES + 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic              fail_seen;

  logic [15:0]      expected;
  logic             mism;
  logic [ERR_W-1:0] err_next;
  logic             last_pass;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    expected  = stim ? EXP_HI : EXP_LO;
    mism      = |((dut_out ^ expected) & CHECK_MASK);
    err_next  = err_count;
    if (mism && !(&err_count))
      err_next = err_count + ERR_W'(1);
    last_pass = (pass_cnt == PASS_W'(PASSES - 1));
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      pass_cnt        <= '0;
      fail_seen       <= 1'b0;
      stim            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_stim <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count       <= '0;
            pass            <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_stim <= 1'b0;
            fail_seen       <= 1'b0;
            pass_cnt        <= '0;
            stim            <= 1'b0;
            busy            <= 1'b1;
            state           <= DRIVE;
          end
        end

        DRIVE: begin
          wait_cnt <= WAIT_W'(SETTLE_CYCLES);
          state    <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end

        SETTLE: begin
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1))
            state <= SAMPLE;
        end

        SAMPLE: begin
          err_count <= err_next;
          // Capture is keyed on a per-run flag so it stays correct once err_count saturates.
          if (mism && !fail_seen) begin
            fail_seen       <= 1'b1;
            first_fail_vec  <= dut_out;
            first_fail_stim <= stim;
          end
          if (!stim) begin
            stim  <= 1'b1;
            state <= DRIVE;
          end else begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            stim     <= 1'b0;
            if (last_pass) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= DONE;
            end else begin
              state <= DRIVE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schematic_test_checker.sv
// Randomized bench for schematic_test_checker: a harness DUT model with injectable faults
// drives dut_out, and a cycle-indexed reference of the sweep predicts every output.
module tb_schematic_test_checker;

  localparam logic [15:0] EXP_LO = 16'hFA52;
  localparam logic [15:0] EXP_HI = 16'hFA15;
  localparam logic [15:0] MASK   = 16'hFF7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] dout_a, dout_b;
  logic        stim_a, busy_a, done_a, pass_a, ffs_a;
  logic        stim_b, busy_b, done_b, pass_b, ffs_b;
  logic [7:0]  err_a;
  logic [1:0]  err_b;
  logic [15:0] ffv_a, ffv_b;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic        o_stim, o_busy, o_done, o_pass, o_ffs;
  logic [31:0] o_err;
  logic [15:0] o_ffv;

  always #5 clk = ~clk;

  schematic_test_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffv_a), .first_fail_stim(ffs_a)
  );

  schematic_test_checker #(.SETTLE_CYCLES(0), .PASSES(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffv_b), .first_fail_stim(ffs_b)
  );

  always_comb begin
    o_stim = (sel != 0) ? stim_b : stim_a;
    o_busy = (sel != 0) ? busy_b : busy_a;
    o_done = (sel != 0) ? done_b : done_a;
    o_pass = (sel != 0) ? pass_b : pass_a;
    o_ffs  = (sel != 0) ? ffs_b  : ffs_a;
    o_ffv  = (sel != 0) ? ffv_b  : ffv_a;
    o_err  = (sel != 0) ? 32'(err_b) : 32'(err_a);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Harness DUT: 0 golden, 1 bit b stuck at 1, 2 bit 7 random, 3 tied to k, 4 sporadic noise.
  function automatic logic [15:0] model_out(int mode, logic s, logic [15:0] k, int b);
    logic [15:0] g;
    logic        r;
    g = s ? EXP_HI : EXP_LO;
    r = 1'($urandom_range(0, 1));
    case (mode)
      1:       return g | (16'h1 << b);
      2:       return g ^ {8'h00, r, 7'h00};
      3:       return k;
      4:       return ($urandom_range(0, 3) == 0) ? (g ^ 16'($urandom)) : g;
      default: return g;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which != 0) start_b = v;
    else            start_a = v;
  endtask

  task automatic drive_out(input int which, input logic [15:0] v);
    if (which != 0) dout_b = v;
    else            dout_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stim"}, 32'(o_stim), 0);
    check({tag, " busy"}, 32'(o_busy), 0);
    check({tag, " done"}, 32'(o_done), 0);
    check({tag, " pass"}, 32'(o_pass), 0);
    check({tag, " err"},  o_err, 0);
    check({tag, " ffv"},  32'(o_ffv), 0);
    check({tag, " ffs"},  32'(o_ffs), 0);
  endtask

  // Called at a negedge with the selected checker idle; returns at a negedge with start low.
  task automatic run(input int which, input int mode, input logic [15:0] k, input int b,
                     input bit repulse, input int abort_at);
    int          s_cyc  = (which != 0) ? 0 : 2;
    int          p      = (which != 0) ? 2 : 4;
    int          n      = 2 * p * (s_cyc + 2);
    int          errmax = (which != 0) ? 3 : 255;
    logic [15:0] vec [0:63];
    int          errs   = 0;
    bit          seen   = 0;
    logic [15:0] fv     = '0;
    logic        fs     = 1'b0;
    logic [15:0] v;
    logic        st;
    sel = which;
    set_start(which, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        rst_n = 1'b0;
        set_start(which, 1'b0);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("post-abort busy", 32'(o_busy), 0);
          check("post-abort done", 32'(o_done), 0);
        end
        return;
      end
      // Start pulses during the run and in the done cycle must be ignored.
      set_start(which, (repulse && (c == 5 || c == 10)) || c == n + 1);
      check($sformatf("busy c%0d", c), 32'(o_busy), 32'(c <= n));
      check($sformatf("done c%0d", c), 32'(o_done), 32'(c == n + 1));
      check($sformatf("stim c%0d", c), 32'(o_stim),
            (c <= n) ? 32'(((c - 1) / (s_cyc + 2)) % 2) : 0);
      vec[c] = model_out(mode, o_stim, k, b);
      drive_out(which, vec[c]);
    end
    // Sample k observes the value present in cycle (k+1)*(SETTLE+2); stim alternates 0,1.
    for (int s = 0; s < 2 * p; s++) begin
      v  = vec[(s + 1) * (s_cyc + 2)];
      st = 1'(s % 2);
      if (((v ^ (st ? EXP_HI : EXP_LO)) & MASK) != 16'h0) begin
        if (errs < errmax) errs++;
        if (!seen) begin
          seen = 1;
          fv   = v;
          fs   = st;
        end
      end
    end
    @(negedge clk);
    check("end busy", 32'(o_busy), 0);
    check("end done", 32'(o_done), 0);
    check("end pass", 32'(o_pass), 32'(errs == 0));
    check("end err",  o_err, 32'(errs));
    check("end ffv",  32'(o_ffv), 32'(fv));
    check("end ffs",  32'(o_ffs), 32'(fs));
    set_start(which, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    dout_a  = EXP_LO;
    dout_b  = EXP_LO;
    repeat (3) @(negedge clk);
    sel = 0;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, 16'h0, 0, 0, 0);
    run(0, 1, 16'h0, 3, 0, 0);
    run(0, 2, 16'h0, 0, 0, 0);
    run(0, 0, 16'h0, 0, 1, 0);
    run(0, 1, 16'h0, 3, 0, 10);
    run(0, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      run(0, int'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);

    run(1, 3, 16'h0000, 0, 0, 0);
    run(1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      run(1, int'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(0, 15)), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
